// File: rtl/riscv_core.sv
// riscv_core: minimal 16-bit single-cycle core. Executes the instruction word
// on ext_data at every rising clk edge; there is no fetch and no pipeline.
//
// Ports:
//   clk      - sole clock, all state updates on the rising edge
//   PC_rst   - asynchronous active-low reset; clears R0-R3, PC, halt and OutR
//   ext_data - instruction word {op[15:12], rd[11:10], rs[9:8], imm[7:0]}
//   OutR     - registered result, updated only by OUT or reset
module riscv_core (
  input  logic        clk,
  input  logic        PC_rst,
  input  logic [15:0] ext_data,
  output logic [15:0] OutR
);

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0,
    OP_LDI  = 4'h1,
    OP_LDH  = 4'h2,
    OP_MOV  = 4'h3,
    OP_ADD  = 4'h4,
    OP_SUB  = 4'h5,
    OP_AND  = 4'h6,
    OP_OR   = 4'h7,
    OP_XOR  = 4'h8,
    OP_MIN  = 4'h9,
    OP_MAX  = 4'hA,
    OP_OUT  = 4'hB,
    OP_SLT  = 4'hC,
    OP_SHL  = 4'hD,
    OP_SHR  = 4'hE,
    OP_HALT = 4'hF
  } op_t;

  op_t         op;
  logic [1:0]  rd;
  logic [1:0]  rs;
  logic [7:0]  imm;

  logic [15:0] regs [4];
  logic [7:0]  pc;
  logic        halt;

  logic [15:0] a;
  logic [15:0] b;
  logic [15:0] result;
  logic        wr_en;
  logic        out_en;
  logic        halt_set;

  assign op  = op_t'(ext_data[15:12]);
  assign rd  = ext_data[11:10];
  assign rs  = ext_data[9:8];
  assign imm = ext_data[7:0];

  // Operands come from pre-edge register contents, so rd == rs simply
  // reads the same value twice.
  always_comb begin
    a        = regs[rd];
    b        = regs[rs];
    result   = a;
    wr_en    = 1'b0;
    out_en   = 1'b0;
    halt_set = 1'b0;
    case (op)
      OP_NOP:  ;
      OP_LDI:  begin result = {8'h00, imm};             wr_en = 1'b1; end
      OP_LDH:  begin result = {imm, a[7:0]};            wr_en = 1'b1; end
      OP_MOV:  begin result = b;                        wr_en = 1'b1; end
      OP_ADD:  begin result = a + b;                    wr_en = 1'b1; end
      OP_SUB:  begin result = a - b;                    wr_en = 1'b1; end
      OP_AND:  begin result = a & b;                    wr_en = 1'b1; end
      OP_OR:   begin result = a | b;                    wr_en = 1'b1; end
      OP_XOR:  begin result = a ^ b;                    wr_en = 1'b1; end
      OP_MIN:  begin result = (a < b) ? a : b;          wr_en = 1'b1; end
      OP_MAX:  begin result = (a > b) ? a : b;          wr_en = 1'b1; end
      OP_OUT:  out_en = 1'b1;
      OP_SLT:  begin result = {15'b0, (a < b)};         wr_en = 1'b1; end
      OP_SHL:  begin result = a << imm[3:0];            wr_en = 1'b1; end
      OP_SHR:  begin result = a >> imm[3:0];            wr_en = 1'b1; end
      OP_HALT: halt_set = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge PC_rst) begin
    if (!PC_rst) begin
      for (int unsigned i = 0; i < 4; i++) regs[i] <= '0;
      pc   <= '0;
      halt <= 1'b0;
      OutR <= '0;
    end else if (!halt) begin
      // PC advances on every executed edge, the HALT edge included.
      pc <= pc + 8'd1;
      if (wr_en)    regs[rd] <= result;
      if (out_en)   OutR     <= b;
      if (halt_set) halt     <= 1'b1;
    end
  end

endmodule

// File: tb/tb_riscv_core.sv
module tb_riscv_core;

  logic        clk;
  logic        PC_rst;
  logic [15:0] ext_data;
  logic [15:0] OutR;

  riscv_core dut (
    .clk      (clk),
    .PC_rst   (PC_rst),
    .ext_data (ext_data),
    .OutR     (OutR)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] exp_q [$];
  string       name_q [$];
  int          n_checks = 0;
  int          n_fail   = 0;

  localparam logic [3:0] NOP = 4'h0, LDI = 4'h1, LDH = 4'h2, MOV = 4'h3,
                         ADD = 4'h4, SUB = 4'h5, AND = 4'h6, OR  = 4'h7,
                         XOR = 4'h8, MIN = 4'h9, MAX = 4'hA, OUT = 4'hB,
                         SLT = 4'hC, SHL = 4'hD, SHR = 4'hE, HLT = 4'hF;

  function automatic logic [15:0] enc(logic [3:0] op, logic [1:0] rd,
                                      logic [1:0] rs, logic [7:0] imm);
    return {op, rd, rs, imm};
  endfunction

  task automatic expect_out(input logic [15:0] v, input string nm);
    exp_q.push_back(v);
    name_q.push_back(nm);
  endtask

  // Drive one instruction mid-cycle; it executes on the following rising edge.
  task automatic exec(input logic [15:0] instr, input bit chk = 0,
                      input logic [15:0] v = '0, input string nm = "");
    @(negedge clk);
    ext_data = instr;
    @(posedge clk);
    if (chk) expect_out(v, nm);
  endtask

  // Assert reset between edges, check at the next falling edge, release
  // before the following rising edge.
  task automatic rst_pulse(input string nm);
    @(posedge clk);
    ext_data = '0;
    #2 PC_rst = 1'b0;
    expect_out(16'h0000, nm);
    @(negedge clk);
    #1 PC_rst = 1'b1;
  endtask

  // Monitor: compares OutR against queued expectations once per cycle,
  // away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      while (exp_q.size() > 0) begin
        logic [15:0] e;
        string       nm;
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        n_checks++;
        if (OutR !== e) begin
          n_fail++;
          $display("FAIL %s: OutR=%h expected %h", nm, OutR, e);
        end
      end
    end
  end

  initial begin
    PC_rst   = 1'b0;
    ext_data = '0;
    expect_out(16'h0000, "reset_initial");
    repeat (2) @(posedge clk);
    @(negedge clk);
    PC_rst = 1'b1;

    // Load / out
    exec(enc(LDI, 2'd0, 2'd0, 8'h34));
    exec(enc(LDH, 2'd0, 2'd0, 8'h12));
    exec(enc(OUT, 2'd0, 2'd0, 8'h00), 1, 16'h1234, "ldi_ldh_out");
    exec(16'h0FFF, 1, 16'h1234, "nop_holds_out");
    rst_pulse("reset_async_mid");

    // Min / max
    exec(enc(LDI, 2'd0, 2'd0, 8'd5));
    exec(enc(LDI, 2'd1, 2'd0, 8'd9));
    exec(enc(MOV, 2'd2, 2'd0, 8'h00));
    exec(enc(MIN, 2'd2, 2'd1, 8'h00));
    exec(enc(OUT, 2'd0, 2'd2, 8'h00), 1, 16'h0005, "min");
    exec(enc(MAX, 2'd0, 2'd1, 8'h00));
    exec(enc(OUT, 2'd0, 2'd0, 8'h00), 1, 16'h0009, "max");
    exec(enc(MIN, 2'd1, 2'd1, 8'h00));
    exec(enc(OUT, 2'd0, 2'd1, 8'h00), 1, 16'h0009, "min_equal");

    // Wrap
    exec(enc(LDI, 2'd0, 2'd0, 8'd0));
    exec(enc(LDI, 2'd1, 2'd0, 8'd1));
    exec(enc(SUB, 2'd0, 2'd1, 8'h00));
    exec(enc(OUT, 2'd0, 2'd0, 8'h00), 1, 16'hFFFF, "sub_wrap");
    exec(enc(ADD, 2'd0, 2'd1, 8'h00));
    exec(enc(OUT, 2'd0, 2'd0, 8'h00), 1, 16'h0000, "add_wrap");

    // Logic ops
    exec(enc(LDI, 2'd2, 2'd0, 8'hF0));
    exec(enc(LDH, 2'd2, 2'd0, 8'h0F));
    exec(enc(LDI, 2'd3, 2'd0, 8'h3C));
    exec(enc(AND, 2'd3, 2'd2, 8'h00));
    exec(enc(OUT, 2'd0, 2'd3, 8'h00), 1, 16'h0030, "and");
    exec(enc(LDI, 2'd3, 2'd0, 8'h3C));
    exec(enc(OR,  2'd3, 2'd2, 8'h00));
    exec(enc(OUT, 2'd0, 2'd3, 8'h00), 1, 16'h0FFC, "or");
    exec(enc(XOR, 2'd3, 2'd2, 8'h00));
    exec(enc(OUT, 2'd0, 2'd3, 8'h00), 1, 16'h000C, "xor");

    // Shift / SLT
    exec(enc(LDI, 2'd1, 2'd0, 8'h81));
    exec(enc(SHL, 2'd1, 2'd0, 8'h04));
    exec(enc(OUT, 2'd0, 2'd1, 8'h00), 1, 16'h0810, "shl");
    exec(enc(SLT, 2'd1, 2'd1, 8'h00));
    exec(enc(OUT, 2'd0, 2'd1, 8'h00), 1, 16'h0000, "slt_self");
    exec(enc(LDI, 2'd0, 2'd0, 8'd2));
    exec(enc(LDI, 2'd1, 2'd0, 8'd3));
    exec(enc(SLT, 2'd0, 2'd1, 8'h00));
    exec(enc(OUT, 2'd0, 2'd0, 8'h00), 1, 16'h0001, "slt_true");
    exec(enc(LDI, 2'd2, 2'd0, 8'h80));
    exec(enc(LDH, 2'd2, 2'd0, 8'hF0));
    exec(enc(SHR, 2'd2, 2'd0, 8'h14));
    exec(enc(OUT, 2'd0, 2'd2, 8'h00), 1, 16'h0F08, "shr_imm_low4");

    // Halt
    exec(enc(LDI, 2'd3, 2'd0, 8'd7));
    exec(enc(OUT, 2'd0, 2'd3, 8'h00), 1, 16'h0007, "pre_halt_out");
    exec(enc(HLT, 2'd0, 2'd0, 8'h00));
    exec(enc(LDI, 2'd3, 2'd0, 8'd9), 1, 16'h0007, "halted_ldi");
    exec(enc(OUT, 2'd0, 2'd3, 8'h00), 1, 16'h0007, "halted_out");
    rst_pulse("reset_while_halted");
    exec(enc(LDI, 2'd1, 2'd0, 8'd3));
    exec(enc(ADD, 2'd1, 2'd3, 8'h00));
    exec(enc(OUT, 2'd0, 2'd1, 8'h00), 1, 16'h0003, "resume_regs_cleared");

    // Clock edges ignored while reset held low
    @(negedge clk);
    PC_rst = 1'b0;
    exec(enc(LDI, 2'd0, 2'd0, 8'h55), 1, 16'h0000, "rst_hold_ldi");
    exec(enc(OUT, 2'd0, 2'd0, 8'h00), 1, 16'h0000, "rst_hold_out");
    @(negedge clk);
    ext_data = '0;
    PC_rst   = 1'b1;
    exec(enc(LDI, 2'd1, 2'd0, 8'h22));
    exec(enc(ADD, 2'd1, 2'd0, 8'h00));
    exec(enc(OUT, 2'd0, 2'd1, 8'h00), 1, 16'h0022, "post_rst_hold");

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    @(negedge clk);
    if (exp_q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
